// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard receiver: deserializes frames into one-cycle make codes, strips F0/E0 prefixes.
// Optional PS2_REPEAT_FILTER_EN suppresses typematic repeats of the last emitted make code.
module ps2_keycode_rx #(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter logic [7:0]  IDLE_CODE      = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_code,
    output logic       key_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_DATA, S_PARITY, S_STOP, S_DECODE} state_t;

    state_t        state, state_n;
    logic [1:0]    clk_sync, data_sync;
    logic          clk_prev;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shreg, shreg_n;
    logic          parity, parity_n;
    logic [TW-1:0] tmo_cnt, tmo_cnt_n;
    logic          break_pending, break_pending_n;
    logic          ext_pending, ext_pending_n;
    logic [7:0]    key_code_n;
    logic          key_valid_n, frame_err_n;
    logic          fe, sd;
`ifdef PS2_REPEAT_FILTER_EN
    logic [7:0]    last_make, last_make_n;
`endif

    assign fe   = clk_prev & ~clk_sync[1];
    assign sd   = data_sync[1];
    assign busy = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync      <= '1;
            data_sync     <= '1;
            clk_prev      <= 1'b1;
            state         <= S_IDLE;
            bit_cnt       <= '0;
            shreg         <= '0;
            parity        <= 1'b0;
            tmo_cnt       <= '0;
            break_pending <= 1'b0;
            ext_pending   <= 1'b0;
            key_code      <= IDLE_CODE;
            key_valid     <= 1'b0;
            frame_err     <= 1'b0;
`ifdef PS2_REPEAT_FILTER_EN
            last_make     <= 8'h00;
`endif
        end else begin
            clk_sync      <= {clk_sync[0], ps2_clk};
            data_sync     <= {data_sync[0], ps2_data};
            clk_prev      <= clk_sync[1];
            state         <= state_n;
            bit_cnt       <= bit_cnt_n;
            shreg         <= shreg_n;
            parity        <= parity_n;
            tmo_cnt       <= tmo_cnt_n;
            break_pending <= break_pending_n;
            ext_pending   <= ext_pending_n;
            key_code      <= key_code_n;
            key_valid     <= key_valid_n;
            frame_err     <= frame_err_n;
`ifdef PS2_REPEAT_FILTER_EN
            last_make     <= last_make_n;
`endif
        end
    end

    always_comb begin
        state_n         = state;
        bit_cnt_n       = bit_cnt;
        shreg_n         = shreg;
        parity_n        = parity;
        tmo_cnt_n       = '0;
        break_pending_n = break_pending;
        ext_pending_n   = ext_pending;
        key_code_n      = IDLE_CODE;
        key_valid_n     = 1'b0;
        frame_err_n     = 1'b0;
`ifdef PS2_REPEAT_FILTER_EN
        last_make_n     = last_make;
`endif
        case (state)
            S_IDLE: begin
                if (fe && !sd) begin
                    state_n   = S_DATA;
                    bit_cnt_n = '0;
                end
            end
            S_DATA, S_PARITY, S_STOP: begin
                if (fe) begin
                    // an edge always wins over an expiring timeout
                    if (state == S_DATA) begin
                        shreg_n   = {sd, shreg[7:1]};
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state_n = S_PARITY;
                    end else if (state == S_PARITY) begin
                        parity_n = sd;
                        state_n  = S_STOP;
                    end else if (sd && ((^shreg) ^ parity)) begin
                        state_n = S_DECODE;
                    end else begin
                        frame_err_n     = 1'b1;
                        break_pending_n = 1'b0;
                        ext_pending_n   = 1'b0;
                        state_n         = S_IDLE;
                    end
                end else if (tmo_cnt == TMO_MAX) begin
                    frame_err_n     = 1'b1;
                    break_pending_n = 1'b0;
                    ext_pending_n   = 1'b0;
                    state_n         = S_IDLE;
                end else begin
                    tmo_cnt_n = tmo_cnt + 1'b1;
                end
            end
            S_DECODE: begin
                state_n = S_IDLE;
                if (shreg == 8'hF0) begin
                    break_pending_n = 1'b1;
                end else if (shreg == 8'hE0) begin
                    ext_pending_n = 1'b1;
                end else if (break_pending || ext_pending) begin
`ifdef PS2_REPEAT_FILTER_EN
                    if (break_pending && shreg == last_make) last_make_n = 8'h00;
`endif
                    break_pending_n = 1'b0;
                    ext_pending_n   = 1'b0;
                end else begin
`ifdef PS2_REPEAT_FILTER_EN
                    if (shreg != last_make) begin
                        key_code_n  = shreg;
                        key_valid_n = 1'b1;
                        last_make_n = shreg;
                    end
`else
                    key_code_n  = shreg;
                    key_valid_n = 1'b1;
`endif
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Directed testbench for ps2_keycode_rx; expectations follow PS2_REPEAT_FILTER_EN when defined.
module tb_ps2_keycode_rx;

    localparam int HALF = 8;
    localparam int TMO  = 200;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] key_code;
    logic       key_valid, frame_err, busy;

    int checks = 0;
    int failures = 0;
    int vld_cnt = 0;
    int err_cnt = 0;
    logic [7:0] last_code = 8'h00;
    int v0, e0;

    ps2_keycode_rx #(.TIMEOUT_CYCLES(TMO), .IDLE_CODE(8'h00)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .key_code(key_code), .key_valid(key_valid), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (key_valid) begin
            vld_cnt   = vld_cnt + 1;
            last_code = key_code;
        end
        if (frame_err) err_cnt = err_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        @(negedge clk);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_flip);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit((~^d) ^ par_flip);
        ps2_bit(1'b1);
        repeat (10) @(negedge clk);
    endtask

    initial begin
        repeat (4) @(negedge clk);
        reset = 1'b0;
        chk("rst_code", key_code, 8'h00);
        chk("rst_valid", key_valid, 1'b0);
        chk("rst_err", frame_err, 1'b0);
        chk("rst_busy", busy, 1'b0);

        // 0x16 with stop-bit latency checked cycle by cycle
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(i == 1 || i == 2 || i == 4);
        ps2_bit(1'b0);
        @(negedge clk);
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        chk("lat_pre_valid", key_valid, 1'b0);
        @(negedge clk);
        chk("lat_valid", key_valid, 1'b1);
        chk("lat_code", key_code, 8'h16);
        @(negedge clk);
        chk("lat_post_valid", key_valid, 1'b0);
        chk("lat_post_code", key_code, 8'h00);
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (10) @(negedge clk);
        chk("f16_vld_cnt", vld_cnt, 1);
        chk("f16_err_cnt", err_cnt, 0);

        send_frame(8'hF0, 1'b0);
        send_frame(8'h16, 1'b0);
        chk("brk_vld_cnt", vld_cnt, 1);
        chk("brk_code_idle", key_code, 8'h00);
        send_frame(8'h1A, 1'b0);
        chk("f1a_vld_cnt", vld_cnt, 2);
        chk("f1a_code", last_code, 8'h1A);

        send_frame(8'h1E, 1'b1);
        chk("par_err_cnt", err_cnt, 1);
        chk("par_vld_cnt", vld_cnt, 2);
        send_frame(8'h22, 1'b0);
        chk("f22_code", last_code, 8'h22);
        chk("f22_vld_cnt", vld_cnt, 3);

        // stalled frame: start + 5 data bits then silence
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(1'b1);
        repeat (TMO / 2) @(negedge clk);
        chk("tmo_busy_mid", busy, 1'b1);
        chk("tmo_err_mid", err_cnt, 1);
        repeat (TMO) @(negedge clk);
        chk("tmo_err_cnt", err_cnt, 2);
        chk("tmo_busy", busy, 1'b0);
        send_frame(8'h15, 1'b0);
        chk("f15_code", last_code, 8'h15);
        chk("f15_vld_cnt", vld_cnt, 4);

        ps2_bit(1'b1);
        repeat (5) @(negedge clk);
        chk("glitch_busy", busy, 1'b0);
        chk("glitch_err", err_cnt, 2);

        send_frame(8'hE0, 1'b0);
        send_frame(8'h75, 1'b0);
        chk("ext_vld_cnt", vld_cnt, 4);

        // reset mid-frame after 4 data bits of 0x36
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(i == 1 || i == 2);
        chk("prerst_busy", busy, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_valid", key_valid, 1'b0);
        chk("mrst_code", key_code, 8'h00);
        chk("mrst_err", frame_err, 1'b0);
        repeat (TMO + 20) @(negedge clk);
        chk("mrst_no_tmo", err_cnt, 2);
        send_frame(8'h36, 1'b0);
        chk("f36_code", last_code, 8'h36);
        chk("f36_vld_cnt", vld_cnt, 5);

        v0 = vld_cnt;
        send_frame(8'h16, 1'b0);
        send_frame(8'h16, 1'b0);
`ifdef PS2_REPEAT_FILTER_EN
        chk("rep_vld_cnt", vld_cnt - v0, 1);
`else
        chk("rep_vld_cnt", vld_cnt - v0, 2);
`endif
        v0 = vld_cnt;
        send_frame(8'hF0, 1'b0);
        send_frame(8'h16, 1'b0);
        send_frame(8'h16, 1'b0);
        chk("rel_rep_vld_cnt", vld_cnt - v0, 1);
        chk("rel_rep_code", last_code, 8'h16);
        e0 = err_cnt;
        chk("final_err_cnt", e0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
